// File: rtl/current_cmp_sar_ctrl.sv
// current_cmp_sar_ctrl
// Successive-approximation controller for the on-chip analog current
// comparator. Each trial drives a binary-weighted trim code to the current DAC
// and waits SETTLE_CYCLES clocks. It then samples the synchronised comparator
// decision and keeps or clears the trial bit. After WIDTH trials the code is
// published on result and done pulses for one cycle.
//
// Parameters:
//   WIDTH          DAC code / result width, 2..8
//   SETTLE_CYCLES  clocks per trial before sampling, >= 2 (covers the
//                  2-flop synchroniser latency)
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ena       design enable; low aborts a conversion in progress
//   start     level-sampled conversion request, honoured only in IDLE
//   cmp_in    raw asynchronous comparator output (1 = Iin >= Idac)
//   dac_code  trial code to the current DAC; holds the final code while idle
//   busy      high from the start edge until DONE is exited
//   done      one-cycle pulse coinciding with the result update
//   result    last completed conversion
//
// Optional feature (macro CURRENT_CMP_MAJORITY_EN):
//   SAMPLE lasts three cycles and the bit decision is the majority of the
//   three synchronised comparator samples.

module current_cmp_sar_ctrl #(
    parameter int WIDTH         = 6,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dac_d, result_d;
    logic             busy_d, done_d;
    logic             sync_q, cmp_s;
    logic             bit_ready, bit_val;
    logic [WIDTH-1:0] bit_mask;
`ifdef CURRENT_CMP_MAJORITY_EN
    logic [1:0]       samp_cnt_q, samp_cnt_d;
    logic [1:0]       samp_hist_q, samp_hist_d;
`endif

    // Two-flop synchroniser for the asynchronous comparator output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            cmp_s  <= 1'b0;
        end else begin
            sync_q <= cmp_in;
            cmp_s  <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= IDX_TOP;
            cnt_q    <= '0;
            dac_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
`ifdef CURRENT_CMP_MAJORITY_EN
            samp_cnt_q  <= '0;
            samp_hist_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dac_code <= dac_d;
            busy     <= busy_d;
            done     <= done_d;
            result   <= result_d;
`ifdef CURRENT_CMP_MAJORITY_EN
            samp_cnt_q  <= samp_cnt_d;
            samp_hist_q <= samp_hist_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dac_d     = dac_code;
        busy_d    = busy;
        done_d    = 1'b0;
        result_d  = result;
        bit_ready = 1'b0;
        bit_val   = cmp_s;
        bit_mask  = ONE << idx_q;
`ifdef CURRENT_CMP_MAJORITY_EN
        samp_cnt_d  = samp_cnt_q;
        samp_hist_d = samp_hist_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start && ena) begin
                    state_d = SETTLE;
                    dac_d   = MSB;
                    idx_d   = IDX_TOP;
                    cnt_d   = CNT_TOP;
                    busy_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = SAMPLE;
`ifdef CURRENT_CMP_MAJORITY_EN
                    samp_cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
`ifdef CURRENT_CMP_MAJORITY_EN
                // The first two cycles only record; the third votes with the
                // live sample so the decision needs no extra cycle.
                if (samp_cnt_q == 2'd2) begin
                    bit_ready = 1'b1;
                    bit_val   = (samp_hist_q[1] & samp_hist_q[0]) |
                                (samp_hist_q[1] & cmp_s) |
                                (samp_hist_q[0] & cmp_s);
                end else begin
                    samp_cnt_d  = samp_cnt_q + 2'd1;
                    samp_hist_d = {samp_hist_q[0], cmp_s};
                end
`else
                bit_ready = 1'b1;
`endif
                if (bit_ready) begin
                    if (!bit_val) begin
                        dac_d = dac_code & ~bit_mask;
                    end
                    if (idx_q == '0) begin
                        // result and done are registered on entry to DONE so
                        // they are valid for exactly the DONE cycle
                        state_d  = DONE;
                        result_d = dac_d;
                        done_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        dac_d   = dac_d | (bit_mask >> 1);
                        cnt_d   = CNT_TOP;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Enable drop aborts from any active state without publishing a result
        if (!ena && (state_q != IDLE)) begin
            state_d  = IDLE;
            dac_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            result_d = result;
            idx_d    = IDX_TOP;
            cnt_d    = '0;
        end
    end

endmodule

// File: tb/tb_current_cmp_sar_ctrl.sv
// Self-checking bench for current_cmp_sar_ctrl (WIDTH=6, SETTLE_CYCLES=4).
// A behavioural SAR model tracks the conversion timeline in plain arithmetic;
// a compare process checks every output on every cycle out of reset, and
// directed sequences pin trial order, latency, abort and reset behaviour.

module tb_current_cmp_sar_ctrl;

    localparam int W = 6;
    localparam int S = 4;
`ifdef CURRENT_CMP_MAJORITY_EN
    localparam int NS       = 3;
    localparam int BUSY_LIT = 43;
`else
    localparam int NS       = 1;
    localparam int BUSY_LIT = 31;
`endif
    localparam int P = S + NS;   // cycles per bit trial
    localparam int T = W * P;    // phase of the done cycle

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         ena    = 1'b0;
    logic         start  = 1'b0;
    logic         cmp_in = 1'b0;
    logic [W-1:0] dac_code;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    current_cmp_sar_ctrl #(
        .WIDTH        (W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .cmp_in  (cmp_in),
        .dac_code(dac_code),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // comparator environment: 0 = threshold at target, 1 = tied 1, 2 = tied 0
    int mode      = 0;
    int target    = 0;
    bit glitch_on = 1'b0;
    int gsel[W];

    // behavioural model
    bit m_active = 1'b0;
    int m_p      = 0;
    int m_acc    = 0;
    int m_dac    = 0;
    int m_res    = 0;

    // observation trackers
    int n_busy, n_done, done_res, tick_i, first_done_i, rebusy_i;
    bit prev_busy;
    int seq[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cmp_truth(input int code);
        case (mode)
            0:       return target >= code;
            1:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Model: advances one clock edge from plain SAR rules
    initial begin
        int trial;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 1'b0;
                m_p      = 0;
                m_acc    = 0;
                m_dac    = 0;
                m_res    = 0;
            end else if (m_active) begin
                if (!ena) begin
                    m_active = 1'b0;
                    m_dac    = 0;
                end else if (m_p == T) begin
                    m_active = 1'b0;
                end else begin
                    if (m_p % P == P - 1) begin
                        trial = m_acc + (1 << (W - 1 - m_p / P));
                        if (cmp_truth(trial)) m_acc = trial;
                    end
                    m_p++;
                    if (m_p == T) begin
                        m_dac = m_acc;
                        m_res = m_acc;
                    end else begin
                        m_dac = m_acc + (1 << (W - 1 - m_p / P));
                    end
                end
            end else if (start && ena) begin
                m_active = 1'b1;
                m_p      = 0;
                m_acc    = 0;
                m_dac    = 1 << (W - 1);
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                chk("cyc_busy",   int'(busy),     int'(m_active));
                chk("cyc_done",   int'(done),     int'(m_active && (m_p == T)));
                chk("cyc_dac",    int'(dac_code), m_dac);
                chk("cyc_result", int'(result),   m_res);
            end
        end
    end

    task automatic clear_obs();
        n_busy       = 0;
        n_done       = 0;
        done_res     = -1;
        tick_i       = 0;
        first_done_i = -1;
        rebusy_i     = -1;
        prev_busy    = busy;
        seq.delete();
    endtask

    // Observe the cycle that just ran, then drive inputs for the next edge
    task automatic tick(input bit st, input bit en);
        logic c;
        @(negedge clk);
        if (busy) n_busy++;
        if (done) begin
            n_done++;
            done_res = int'(result);
            if (first_done_i < 0) first_done_i = tick_i;
        end
        if (busy && !prev_busy && (n_done > 0) && (rebusy_i < 0)) rebusy_i = tick_i;
        if (busy && !done && ((seq.size() == 0) || (seq[$] != int'(dac_code))))
            seq.push_back(int'(dac_code));
        prev_busy = busy;
        tick_i++;
        start = st;
        ena   = en;
        c = cmp_truth(int'(dac_code));
        // glitch lands on sample offset S+gsel after the 2-flop delay
        if ((NS == 3) && glitch_on && m_active && (m_p < T) &&
            ((m_p % P) == S + gsel[m_p / P] - 2))
            c = ~c;
        cmp_in = c;
    endtask

    task automatic run(input int md, input int tgt, input int n, input int repulse_at,
                       input int drop_at, input bit hold);
        mode      = md;
        target    = tgt;
        glitch_on = (NS == 3);
        for (int k = 0; k < W; k++) gsel[k] = $urandom_range(0, 2);
        clear_obs();
        for (int i = 0; i < n; i++)
            tick(hold || (i == 0) || (i == repulse_at), i != drop_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[6] = '{32, 48, 40, 36, 38, 39};
        int md, tgt, ab, rp, n, expv;

        #12;
        chk("rst_dac",    int'(dac_code), 0);
        chk("rst_busy",   int'(busy),     0);
        chk("rst_done",   int'(done),     0);
        chk("rst_result", int'(result),   0);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick(1'b0, 1'b1);

        // Target 38: trial order, latency, single done, held code
        run(0, 38, T + 2, -1, -1, 1'b0);
        chk("t38_trials_n", seq.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < seq.size()) chk("t38_trial", seq[k], exp_seq[k]);
        chk("t38_busy_cycles", n_busy, BUSY_LIT);
        chk("t38_done_tick", first_done_i, BUSY_LIT);
        chk("t38_done_count", n_done, 1);
        chk("t38_result", done_res, 38);
        tick(1'b0, 1'b1);
        chk("t38_dac_hold", int'(dac_code), 38);

        // Enable dropped at cycle 15
        run(0, 38, 20, -1, 15, 1'b0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dac", int'(dac_code), 0);
        chk("abort_done_count", n_done, 0);
        chk("abort_result", int'(result), 38);

        // Tied comparator extremes
        run(1, 0, T + 2, -1, -1, 1'b0);
        chk("tie1_result", done_res, 63);
        chk("tie1_busy_cycles", n_busy, BUSY_LIT);
        run(2, 0, T + 2, -1, -1, 1'b0);
        chk("tie0_result", done_res, 0);
        chk("tie0_busy_cycles", n_busy, BUSY_LIT);

        // start re-pulsed while busy is ignored
        run(0, 21, T + 4, 10, -1, 1'b0);
        chk("repulse_done_count", n_done, 1);
        chk("repulse_result", done_res, 21);
        chk("repulse_busy_cycles", n_busy, BUSY_LIT);

        // start held high: one idle cycle between conversions
        run(0, 38, 2 * (T + 1) + 3, -1, -1, 1'b1);
        chk("held_rebusy_gap", rebusy_i - first_done_i, 2);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);

        // Asynchronous reset mid-conversion, then a clean conversion
        run(0, 38, 21, -1, -1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dac",    int'(dac_code), 0);
        chk("arst_busy",   int'(busy),     0);
        chk("arst_done",   int'(done),     0);
        chk("arst_result", int'(result),   0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 38, T + 2, -1, -1, 1'b0);
        chk("post_rst_done_count", n_done, 1);
        chk("post_rst_result", done_res, 38);

        // Randomised conversions with occasional aborts and stray starts
        for (int r = 0; r < 40; r++) begin
            md  = $urandom_range(0, 2);
            tgt = $urandom_range(0, 63);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T) : -1;
            rp  = (ab < 0) ? $urandom_range(1, T + 1) : -1;
            n   = T + 2 + $urandom_range(0, 2);
            run(md, tgt, n, rp, ab, 1'b0);
            if (ab < 0) begin
                expv = (md == 0) ? tgt : ((md == 1) ? 63 : 0);
                chk("rand_done_count", n_done, 1);
                chk("rand_result", done_res, expv);
            end else begin
                chk("rand_abort_done_count", n_done, 0);
            end
        end

        tick(1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
